// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - start/done handshake and result bus between control FSM and seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             carry;
    logic             div_by_zero;

    modport master (
        output start, opcode, operand1, operand2,
        input  busy, done, result, result_hi, zero, carry, div_by_zero
    );

    modport slave (
        input  start, opcode, operand1, operand2,
        output busy, done, result, result_hi, zero, carry, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: 1-cycle logic/arith ops, iterative shift-add mul and restoring div
// Optional iterative divider enabled by defining SEQ_ALU_DIV_EN.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    seq_alu_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ITER_MUL = 2'd1
`ifdef SEQ_ALU_DIV_EN
        ,ITER_DIV = 2'd2
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] op1, op2;
    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    assign op1      = bus.operand1;
    assign op2      = bus.operand2;
    assign add_full = {1'b0, op1} + {1'b0, op2};
    assign sub_full = {1'b0, op1} - {1'b0, op2};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (bus.opcode)
            4'h0: begin alu_res = add_full[WIDTH-1:0]; alu_carry = add_full[WIDTH]; end
            4'h1: begin alu_res = sub_full[WIDTH-1:0]; alu_carry = sub_full[WIDTH]; end
            4'h4: begin alu_res = {op1[WIDTH-2:0], 1'b0}; alu_carry = op1[WIDTH-1]; end
            4'h5: begin alu_res = {1'b0, op1[WIDTH-1:1]}; alu_carry = op1[0]; end
            4'h6: alu_res = {op1[WIDTH-2:0], op1[WIDTH-1]};
            4'h7: alu_res = {op1[0], op1[WIDTH-1:1]};
            4'h8: alu_res = op1 & op2;
            4'h9: alu_res = op1 | op2;
            4'hA: alu_res = op1 ^ op2;
            4'hB: alu_res = ~(op1 | op2);
            4'hC: alu_res = ~(op1 & op2);
            4'hD: alu_res = ~(op1 ^ op2);
            4'hE: alu_res = {{(WIDTH-1){1'b0}}, (op1 > op2)};
            4'hF: alu_res = {{(WIDTH-1){1'b0}}, (op1 == op2)};
            default: ;
        endcase
    end

    // {acc_q, b_q} is the running product; it shifts right one multiplier bit per edge
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_nx, mul_b_nx;
    assign mul_sum    = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_acc_nx = mul_sum[WIDTH:1];
    assign mul_b_nx   = {mul_sum[0], b_q[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    // acc_q holds the partial remainder, b_q shifts dividend bits out and quotient bits in
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] div_rem_nx, div_quo_nx;
    assign div_shift  = {acc_q, b_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, a_q};
    assign div_rem_nx = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_quo_nx = {b_q[WIDTH-2:0], ~div_diff[WIDTH]};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.opcode == 4'h2) begin
                        state_d = ITER_MUL;
                        cnt_d   = '0;
                        a_d     = op1;
                        b_d     = op2;
                        acc_d   = '0;
                    end
`ifdef SEQ_ALU_DIV_EN
                    else if (bus.opcode == 4'h3 && op2 != '0) begin
                        state_d = ITER_DIV;
                        cnt_d   = '0;
                        a_d     = op2;
                        b_d     = op1;
                        acc_d   = '0;
                    end else if (bus.opcode == 4'h3) begin
                        result_d    = '1;
                        result_hi_d = op1;
                        zero_d      = 1'b0;
                        carry_d     = 1'b0;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end
`endif
                    else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        carry_d     = alu_carry;
                        dbz_d       = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            ITER_MUL: begin
                acc_d = mul_acc_nx;
                b_d   = mul_b_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    result_d    = mul_b_nx;
                    result_hi_d = mul_acc_nx;
                    zero_d      = (mul_b_nx == '0);
                    carry_d     = 1'b0;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            ITER_DIV: begin
                acc_d = div_rem_nx;
                b_d   = div_quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    result_d    = div_quo_nx;
                    result_hi_d = div_rem_nx;
                    zero_d      = (div_quo_nx == '0);
                    carry_d     = 1'b0;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.result_hi   = result_hi_q;
    assign bus.zero        = zero_q;
    assign bus.carry       = carry_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - vector table, random ops against an arithmetic model, and handshake corner cases
module tb_seq_alu;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] res, hi;
        logic         z, c, d;
        int           lat;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, b, res, hi,
                                input logic z, c, d, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi;
        v.z = z; v.c = c; v.d = d; v.lat = lat;
        return v;
    endfunction

    // Behavioural reference: straight arithmetic on wide integers
    function automatic vec_t model(input logic [3:0] op, input logic [W-1:0] a, b);
        vec_t v;
        longint unsigned ua, ub, r, h;
        ua = a; ub = b; r = 0; h = 0;
        v.op = op; v.a = a; v.b = b; v.c = 1'b0; v.d = 1'b0; v.lat = 1;
        case (op)
            4'h0: begin r = ua + ub; v.c = (r >= 65536); end
            4'h1: begin r = ua + 65536 - ub; v.c = (ua < ub); end
            4'h2: begin r = ua * ub; h = r / 65536; v.lat = W + 1; end
            4'h3: begin
`ifdef SEQ_ALU_DIV_EN
                if (ub == 0) begin r = 65535; h = ua; v.d = 1'b1; end
                else begin r = ua / ub; h = ua % ub; v.lat = W + 1; end
`endif
            end
            4'h4: begin r = ua * 2; v.c = (ua >= 32768); end
            4'h5: begin r = ua / 2; v.c = (ua % 2 == 1); end
            4'h6: r = ua * 2 + ua / 32768;
            4'h7: r = ua / 2 + (ua % 2) * 32768;
            4'h8: r = ua & ub;
            4'h9: r = ua | ub;
            4'hA: r = ua ^ ub;
            4'hB: r = ~(ua | ub);
            4'hC: r = ~(ua & ub);
            4'hD: r = ~(ua ^ ub);
            4'hE: r = (ua > ub) ? 1 : 0;
            default: r = (ua == ub) ? 1 : 0;
        endcase
        v.res = W'(r % 65536);
        v.hi  = W'(h % 65536);
        v.z   = (v.res == 0);
        return v;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, output int lat, output int bcnt);
        bus.opcode = op; bus.operand1 = a; bus.operand2 = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1; bcnt = 0;
        while (!bus.done && lat < 64) begin
            if (bus.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        int lat, bcnt;
        issue(v.op, v.a, v.b, lat, bcnt);
        chk(tag, "done", 32'(bus.done), 32'd1);
        chk(tag, "latency", 32'(lat), 32'(v.lat));
        chk(tag, "busy_cycles", 32'(bcnt), 32'(v.lat - 1));
        chk(tag, "busy_at_done", 32'(bus.busy), 32'd0);
        chk(tag, "result", 32'(bus.result), 32'(v.res));
        chk(tag, "result_hi", 32'(bus.result_hi), 32'(v.hi));
        chk(tag, "zero", 32'(bus.zero), 32'(v.z));
        chk(tag, "carry", 32'(bus.carry), 32'(v.c));
        chk(tag, "div_by_zero", 32'(bus.div_by_zero), 32'(v.d));
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, "busy", 32'(bus.busy), 0);
        chk(tag, "done", 32'(bus.done), 0);
        chk(tag, "result", 32'(bus.result), 0);
        chk(tag, "result_hi", 32'(bus.result_hi), 0);
        chk(tag, "zero", 32'(bus.zero), 0);
        chk(tag, "carry", 32'(bus.carry), 0);
        chk(tag, "div_by_zero", 32'(bus.div_by_zero), 0);
    endtask

    vec_t vecs[$];

    initial begin
        int lat, bcnt, ndone, guard;
        vec_t v;
        bus.start = 1'b0; bus.opcode = '0; bus.operand1 = '0; bus.operand2 = '0;

        vecs.push_back(mk(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 1, 0, 1));
        vecs.push_back(mk(4'h2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 0, 0, 0, 17));
        vecs.push_back(mk(4'h1, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 0, 1, 0, 1));
        vecs.push_back(mk(4'h4, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 0, 1, 0, 1));
        vecs.push_back(mk(4'h5, 16'h8001, 16'h0000, 16'h4000, 16'h0000, 0, 1, 0, 1));
        vecs.push_back(mk(4'h6, 16'h8001, 16'h0000, 16'h0003, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h7, 16'h8001, 16'h0000, 16'hC000, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h8, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h9, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'hA, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 1, 0, 0, 1));
        vecs.push_back(mk(4'hB, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0, 1));
        vecs.push_back(mk(4'hD, 16'h1234, 16'h1234, 16'hFFFF, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'hE, 16'h0005, 16'h0003, 16'h0001, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'hE, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 1, 0, 0, 1));
        vecs.push_back(mk(4'hF, 16'h7777, 16'h7777, 16'h0001, 16'h0000, 0, 0, 0, 1));
        vecs.push_back(mk(4'h2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0, 17));
`ifdef SEQ_ALU_DIV_EN
        vecs.push_back(mk(4'h3, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 0, 17));
        vecs.push_back(mk(4'h3, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 0, 0, 1, 1));
        vecs.push_back(mk(4'h0, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 0, 0, 0, 1));
`else
        vecs.push_back(mk(4'h3, 16'd100, 16'd7, 16'h0000, 16'h0000, 1, 0, 0, 1));
`endif

        #12;
        chk_all_zero("reset_held");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("after_reset");

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 150; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
            if (op == 4'hF && $urandom_range(0, 1) == 1) b = a;
            apply($sformatf("rnd%0d_op%0h", i, op), model(op, a, b));
        end

        // Start during busy is dropped, operand changes are ignored
        bus.opcode = 4'h2; bus.operand1 = 16'd3; bus.operand2 = 16'd5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        repeat (3) begin @(posedge clk); #1; end
        bus.opcode = 4'h0; bus.operand1 = 16'd1; bus.operand2 = 16'd1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.operand1 = 16'd7; bus.operand2 = 16'd9;
        guard = 0;
        while (!bus.done && guard < 40) begin @(posedge clk); #1; guard++; end
        if (bus.done) ndone++;
        chk("busy_start", "done_seen", 32'(bus.done), 1);
        chk("busy_start", "result", 32'(bus.result), 32'd15);
        chk("busy_start", "result_hi", 32'(bus.result_hi), 0);
        // Back-to-back: issue in the done cycle
        bus.opcode = 4'h0; bus.operand1 = 16'd1; bus.operand2 = 16'd1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (bus.done) ndone++;
        chk("b2b", "done", 32'(bus.done), 1);
        chk("b2b", "result", 32'(bus.result), 32'd2);
        @(posedge clk); #1;
        if (bus.done) ndone++;
        chk("b2b", "done_pulse_end", 32'(bus.done), 0);
        chk("b2b", "result_hold", 32'(bus.result), 32'd2);
        chk("b2b", "done_count", 32'(ndone), 32'd2);

        // Reset mid-multiply
        bus.opcode = 4'h2; bus.operand1 = 16'hFFFF; bus.operand2 = 16'hFFFF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("mid_reset", "busy_before", 32'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk); reset_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) begin
                n_fail++;
                $display("FAIL post_reset activity: done=%0b busy=%0b expected 0", bus.done, bus.busy);
            end
        end
        n_chk++;
        v = mk(4'h1, 16'd5, 16'd7, 16'hFFFE, 16'h0000, 0, 1, 0, 1);
        apply("post_reset_sub", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
